// File: rtl/seg_scan_driver.sv
// Purpose : multiplexed 8-digit common-anode 7-segment driver (snapshot, scan, decode, PWM, blink).
// Latency : one register stage; outputs at cycle n+1 reflect scan/shadow/blink state and inputs at cycle n.
// Backpres: none; free-running scan with no handshake, digit inputs sampled once per frame.
module seg_scan_driver #(
  parameter int DWELL      = 4,
  parameter int BLINK_HALF = 250
) (
  input  logic       CLK1K,
  input  logic       RSTN,
  input  logic [3:0] DIG0,
  input  logic [3:0] DIG1,
  input  logic [3:0] DIG2,
  input  logic [3:0] DIG3,
  input  logic [3:0] DIG4,
  input  logic [3:0] DIG5,
  input  logic [3:0] DIG6,
  input  logic [3:0] DIG7,
  input  logic       BLINK_EN,
  input  logic [1:0] BRIGHT,
  input  logic       LZB,
  output logic [6:0] SEG_N,
  output logic       DP_N,
  output logic [7:0] AN_N
);

  // Counter widths; DWELL >= 4 keeps DW >= 2 so BRIGHT always fits.
  localparam int DW = $clog2(DWELL);
  localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

  localparam logic [DW-1:0] DCNT_LAST  = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  // Scan position
  logic [2:0]    idx_q, idx_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  // Frame-coherent copy of the digit inputs
  logic [7:0][3:0] shadow_q, shadow_d;

  // Blink timebase
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  // Registered outputs
  logic [6:0] seg_n_q, seg_n_d;
  logic       dp_n_q, dp_n_d;
  logic [7:0] an_n_q, an_n_d;

  // Helper terms
  logic            slot_end;
  logic            frame_end;
  logic [3:0]      cur_digit;
  logic            lz_slot;
  logic [DW-1:0]   bright_ext;
  logic            blink_off;
  logic            an_on;

  // BCD to active-low segments, bit order g..a; non-BCD codes show a dash.
  function automatic logic [6:0] bcd_to_seg_n(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Slot / frame boundary detection
  always_comb begin
    slot_end  = (dcnt_q == DCNT_LAST);
    frame_end = slot_end && (idx_q == 3'd7);
  end

  // Scan counters: DCNT walks the dwell, IDX advances at dwell end and wraps 7->0
  always_comb begin
    dcnt_d = dcnt_q + DW'(1);
    idx_d  = idx_q;
    if (slot_end) begin
      dcnt_d = '0;
      idx_d  = idx_q + 3'd1;
    end
  end

  // Snapshot all digits only on the last tick of a frame so one frame is always coherent
  always_comb begin
    shadow_d = shadow_q;
    if (frame_end) begin
      shadow_d = {DIG7, DIG6, DIG5, DIG4, DIG3, DIG2, DIG1, DIG0};
    end
  end

  // Blink timebase: runs only while BLINK_EN, otherwise parked at visible phase
  always_comb begin
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    if (BLINK_EN) begin
      blink_ph_d = blink_ph_q;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Next output values from current scan state
  always_comb begin
    cur_digit  = shadow_q[idx_q];
    lz_slot    = (idx_q == 3'd7) || (idx_q == 3'd5);
    bright_ext = DW'(BRIGHT);
    // Gating with BLINK_EN lets the display come back the cycle after it drops.
    blink_off  = BLINK_EN && blink_ph_q;
    an_on      = (dcnt_q <= bright_ext) && !blink_off;

    seg_n_d = bcd_to_seg_n(cur_digit);
    if (LZB && lz_slot && (cur_digit == 4'd0)) begin
      seg_n_d = 7'h7F;
    end

    // Separators sit after digits 2, 4 and 6
    dp_n_d = !((idx_q == 3'd2) || (idx_q == 3'd4) || (idx_q == 3'd6));

    an_n_d = 8'hFF;
    if (an_on) begin
      an_n_d = ~(8'b0000_0001 << idx_q);
    end
  end

  // All state, asynchronously cleared
  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      idx_q       <= '0;
      dcnt_q      <= '0;
      shadow_q    <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      seg_n_q     <= 7'h7F;
      dp_n_q      <= 1'b1;
      an_n_q      <= 8'hFF;
    end else begin
      idx_q       <= idx_d;
      dcnt_q      <= dcnt_d;
      shadow_q    <= shadow_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      seg_n_q     <= seg_n_d;
      dp_n_q      <= dp_n_d;
      an_n_q      <= an_n_d;
    end
  end

  assign SEG_N = seg_n_q;
  assign DP_N  = dp_n_q;
  assign AN_N  = an_n_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Purpose : self-checking bench for seg_scan_driver using a time-based reference model.
// Latency : model predicts each registered output one edge ahead; compared on the falling edge.
// Backpres: none; DUT is free-running, bench drives inputs 1 time unit after each rising edge.
module tb_seg_scan_driver;

  localparam int DWELL      = 4;
  localparam int BLINK_HALF = 250;
  localparam int FRAME      = 8 * DWELL;

  logic       clk;
  logic       rstn;
  logic [3:0] dig [8];
  logic       blink_en;
  logic [1:0] bright;
  logic       lzb;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [7:0] an_n;

  seg_scan_driver #(.DWELL(DWELL), .BLINK_HALF(BLINK_HALF)) dut (
    .CLK1K   (clk),
    .RSTN    (rstn),
    .DIG0    (dig[0]),
    .DIG1    (dig[1]),
    .DIG2    (dig[2]),
    .DIG3    (dig[3]),
    .DIG4    (dig[4]),
    .DIG5    (dig[5]),
    .DIG6    (dig[6]),
    .DIG7    (dig[7]),
    .BLINK_EN(blink_en),
    .BRIGHT  (bright),
    .LZB     (lzb),
    .SEG_N   (seg_n),
    .DP_N    (dp_n),
    .AN_N    (an_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [7:0] an;
  } out_t;

  out_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Segment patterns written straight from the digit table, bit order g..a
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, want);
  endtask

  // Reference model: everything derived from t = edges since reset release
  int         t;
  int         b0;
  logic       en_prev;
  logic [3:0] m_sh [8];

  always @(posedge clk) begin
    int   idx;
    int   dc;
    int   d;
    logic off;
    out_t e;
    cyc++;
    if (!rstn) begin
      t       = 0;
      en_prev = 1'b0;
      b0      = 0;
      for (int i = 0; i < 8; i++) m_sh[i] = 4'd0;
    end else begin
      idx = (t / DWELL) % 8;
      dc  = t % DWELL;
      d   = int'(m_sh[idx]);
      e.seg = (d <= 9) ? seg_tab[d] : 7'b0111111;
      if (lzb && d == 0 && (idx == 5 || idx == 7)) e.seg = 7'h7F;
      e.dp = (idx == 2 || idx == 4 || idx == 6) ? 1'b0 : 1'b1;
      off = 1'b0;
      if (blink_en) begin
        if (!en_prev) b0 = t;
        off = (((t - b0) / BLINK_HALF) % 2) == 1;
      end
      en_prev = blink_en;
      e.an = (dc <= int'(bright) && !off) ? ~(8'h01 << idx) : 8'hFF;
      exp_q.push_back(e);
      if (t % FRAME == FRAME - 1) begin
        for (int i = 0; i < 8; i++) m_sh[i] = dig[i];
      end
      t++;
    end
  end

  // An asynchronous reset discards anything predicted before it
  always @(negedge rstn) exp_q.delete();

  // Compare on the falling edge, well away from the active edge
  always @(negedge clk) begin
    out_t e;
    if (!rstn || exp_q.size() == 0) begin
      check_val("rst_seg", 32'(seg_n), 32'h7F);
      check_val("rst_dp",  32'(dp_n),  32'h1);
      check_val("rst_an",  32'(an_n),  32'hFF);
    end else begin
      e = exp_q.pop_front();
      check_val("seg", 32'(seg_n), 32'(e.seg));
      check_val("dp",  32'(dp_n),  32'(e.dp));
      check_val("an",  32'(an_n),  32'(e.an));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                            input logic [3:0] d3, input logic [3:0] d4, input logic [3:0] d5,
                            input logic [3:0] d6, input logic [3:0] d7);
    dig[0] = d0; dig[1] = d1; dig[2] = d2; dig[3] = d3;
    dig[4] = d4; dig[5] = d5; dig[6] = d6; dig[7] = d7;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    blink_en = 1'b0;
    bright   = 2'd3;
    lzb      = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    step(4);
    rstn = 1'b1;

    // First frame shows zeros; then digits 7,2,3,4,5,6,7,1 (DIG0..DIG7)
    step(3);
    set_digits(4'd7, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1);
    step(FRAME + 3 * DWELL);
    // Mid-frame change of DIG0 must not appear until the following frame
    dig[0] = 4'd0;
    step(2 * FRAME);

    // Non-BCD codes show a dash; DIG0=1 decode
    set_digits(4'd1, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'd9);
    step(2 * FRAME);

    // Leading-zero blanking on and off
    set_digits(4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    lzb = 1'b1;
    step(2 * FRAME);
    lzb = 1'b0;
    step(FRAME);
    lzb = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd2);
    step(2 * FRAME);

    // Brightness sweep, including a change in the middle of a slot
    for (int b = 0; b < 4; b++) begin
      bright = 2'(b);
      step(FRAME + 1);
    end

    // Blink: on 250, off 250, ...; drop BLINK_EN during an off phase
    bright   = 2'd3;
    blink_en = 1'b1;
    step(800);
    blink_en = 1'b0;
    step(40);
    // Re-enable starts visible again, with reduced brightness
    bright   = 2'd1;
    blink_en = 1'b1;
    step(300);
    blink_en = 1'b0;
    step(10);

    // Reset in the middle of a frame, then restart scanning from slot 0
    step(13);
    rstn = 1'b0;
    step(3);
    rstn = 1'b1;
    set_digits(4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2);
    step(3 * FRAME);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
